// File: rtl/eye_scan_pkg.sv
// Eye-scan controller shared types.
// Record fields are sized for the widest supported grid.
package eye_scan_pkg;

  localparam int LOCK_DROPS_W = 8;
  localparam int PHASE_W_MAX  = 16;
  localparam int VOFF_W_MAX   = 16;
  localparam int ERR_W_MAX    = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_LOCK,
    S_SETTLE,
    S_DWELL,
    S_REPORT,
    S_DONE
  } scan_state_e;

  typedef struct packed {
    logic [PHASE_W_MAX-1:0] phase;
    logic [VOFF_W_MAX-1:0]  voff;
    logic [ERR_W_MAX-1:0]   err_cnt;
    logic                   open;
    logic                   sat;
  } eye_point_t;

endpackage

// File: rtl/eye_err_accum.sv
// Dwell down-counter plus saturating main/margin mismatch counter.
// err_nxt/sat_nxt include the current cycle so a point can close on dwell_done.
module eye_err_accum
  import eye_scan_pkg::*;
#(
  parameter int DWELL_W = 20,
  parameter int ERR_W   = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               en,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               bit_err,
  output logic               dwell_done,
  output logic [ERR_W-1:0]   err_nxt,
  output logic               sat_nxt
);

  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  logic [DWELL_W-1:0] left_q;
  logic [DWELL_W-1:0] dwell_ld;
  logic [ERR_W-1:0]   err_q;
  logic               sat_q;

  assign dwell_ld   = (dwell == '0) ? DWELL_W'(1) : dwell;
  assign dwell_done = en && (left_q == DWELL_W'(1));

  always_comb begin
    err_nxt = err_q;
    if (en && bit_err && (err_q != ERR_MAX))
      err_nxt = err_q + ERR_W'(1);
    sat_nxt = sat_q || (err_nxt == ERR_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      left_q <= '0;
      err_q  <= '0;
      sat_q  <= 1'b0;
    end else if (clr) begin
      left_q <= dwell_ld;
      err_q  <= '0;
      sat_q  <= 1'b0;
    end else if (en) begin
      left_q <= left_q - DWELL_W'(1);
      err_q  <= err_nxt;
      sat_q  <= sat_nxt;
    end
  end

endmodule

// File: rtl/eye_scan_controller.sv
// 2-D eye scan sequencer: phase x voltage-offset grid, CDR-lock gated,
// one valid/ready result record per grid point.
module eye_scan_controller
  import eye_scan_pkg::*;
#(
  parameter int PHASE_W    = 6,
  parameter int VOFF_W     = 5,
  parameter int DWELL_W    = 20,
  parameter int ERR_W      = 20,
  parameter int SETTLE_CYC = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [PHASE_W-1:0]      cfg_phase_last,
  input  logic [VOFF_W-1:0]       cfg_voff_last,
  input  logic [DWELL_W-1:0]      cfg_dwell,
  input  logic [ERR_W-1:0]        cfg_err_thresh,
  input  logic                    cdr_lock,
  input  logic                    data_main,
  input  logic                    data_margin,
  output logic                    margin_en,
  output logic [PHASE_W-1:0]      margin_phase,
  output logic [VOFF_W-1:0]       margin_voff,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [PHASE_W-1:0]      res_phase,
  output logic [VOFF_W-1:0]       res_voff,
  output logic [ERR_W-1:0]        res_err_cnt,
  output logic                    res_open,
  output logic                    res_sat,
  output logic                    busy,
  output logic                    done,
  output logic [LOCK_DROPS_W-1:0] lock_drops
);

  localparam int SET_W = $clog2(SETTLE_CYC + 1);

  scan_state_e state, state_nxt;

  logic [PHASE_W-1:0]      phase_last_q, phase_q;
  logic [VOFF_W-1:0]       voff_last_q, voff_q;
  logic [DWELL_W-1:0]      dwell_q;
  logic [ERR_W-1:0]        thresh_q;
  logic [SET_W-1:0]        settle_cnt;
  logic [LOCK_DROPS_W-1:0] drops_q;
  eye_point_t              rec_q, rec_d;

  logic             go, last_pt, xfer;
  logic             acc_clr, acc_en, dwell_done, sat_nxt;
  logic [ERR_W-1:0] err_nxt;
  logic             unused_rec;

  assign go      = (state == S_IDLE) && start && !abort;
  assign last_pt = (phase_q == phase_last_q) && (voff_q == voff_last_q);
  assign xfer    = (state == S_REPORT) && res_ready && !abort;
  assign acc_clr = (state == S_SETTLE) && cdr_lock
                && (settle_cnt == SET_W'(1));
  assign acc_en  = (state == S_DWELL) && cdr_lock && !abort;

  eye_err_accum #(
    .DWELL_W (DWELL_W),
    .ERR_W   (ERR_W)
  ) u_accum (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (acc_clr),
    .en         (acc_en),
    .dwell      (dwell_q),
    .bit_err    (data_main ^ data_margin),
    .dwell_done (dwell_done),
    .err_nxt    (err_nxt),
    .sat_nxt    (sat_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE:      if (start) state_nxt = S_WAIT_LOCK;
        S_WAIT_LOCK: if (cdr_lock) state_nxt = S_SETTLE;
        S_SETTLE: begin
          if (!cdr_lock)    state_nxt = S_WAIT_LOCK;
          else if (acc_clr) state_nxt = S_DWELL;
        end
        S_DWELL: begin
          if (!cdr_lock)       state_nxt = S_WAIT_LOCK;
          else if (dwell_done) state_nxt = S_REPORT;
        end
        S_REPORT: begin
          if (res_ready)
            state_nxt = last_pt ? S_DONE : S_WAIT_LOCK;
        end
        S_DONE:      state_nxt = S_IDLE;
        default:     state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    margin_en = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    res_valid = 1'b0;
    unique case (state)
      S_IDLE: ;
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      S_REPORT: begin
        busy      = 1'b1;
        margin_en = 1'b1;
        res_valid = 1'b1;
      end
      default: begin
        busy      = 1'b1;
        margin_en = 1'b1;
      end
    endcase
  end

  always_comb begin
    rec_d         = '0;
    rec_d.phase   = PHASE_W_MAX'(phase_q);
    rec_d.voff    = VOFF_W_MAX'(voff_q);
    rec_d.err_cnt = ERR_W_MAX'(err_nxt);
    rec_d.open    = (err_nxt <= thresh_q);
    rec_d.sat     = sat_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_last_q <= '0;
      voff_last_q  <= '0;
      dwell_q      <= '0;
      thresh_q     <= '0;
      phase_q      <= '0;
      voff_q       <= '0;
      settle_cnt   <= '0;
      drops_q      <= '0;
      rec_q        <= '0;
    end else begin
      if (go) begin
        phase_last_q <= cfg_phase_last;
        voff_last_q  <= cfg_voff_last;
        dwell_q      <= cfg_dwell;
        thresh_q     <= cfg_err_thresh;
        phase_q      <= '0;
        voff_q       <= '0;
      end else if (xfer && !last_pt) begin
        // voff is the inner loop of the grid
        if (voff_q == voff_last_q) begin
          voff_q  <= '0;
          phase_q <= phase_q + PHASE_W'(1);
        end else begin
          voff_q <= voff_q + VOFF_W'(1);
        end
      end

      if (state == S_WAIT_LOCK)
        settle_cnt <= SET_W'(SETTLE_CYC);
      else if (state == S_SETTLE)
        settle_cnt <= settle_cnt - SET_W'(1);

      if (go)
        drops_q <= '0;
      else if (!abort && !cdr_lock && drops_q != '1
               && (state == S_SETTLE || state == S_DWELL))
        drops_q <= drops_q + LOCK_DROPS_W'(1);

      if (acc_en && dwell_done)
        rec_q <= rec_d;
    end
  end

  assign margin_phase = phase_q;
  assign margin_voff  = voff_q;
  assign res_phase    = rec_q.phase[PHASE_W-1:0];
  assign res_voff     = rec_q.voff[VOFF_W-1:0];
  assign res_err_cnt  = rec_q.err_cnt[ERR_W-1:0];
  assign res_open     = rec_q.open;
  assign res_sat      = rec_q.sat;
  assign lock_drops   = drops_q;
  assign unused_rec   = ^rec_q;

endmodule

// File: doc/eye_scan_controller.md
Name: eye_scan_controller

Overview:
- Sequences a 2-D eye scan on the RX margining sampler: steps the margin sampler over a phase × voltage-offset grid, waits for settling, and counts main/margin sample disagreements over a programmable dwell.
- Emits one result record per grid point over a valid/ready stream.
- Sits beside the RX CDR and eye-statistics tap, and gates measurement on CDR lock.
- Synthesizable; replaces ad-hoc testbench-side eye reporting with hardware sequencing.

Parameters:
- PHASE_W, 6, phase code width (grid columns 0..cfg_phase_last).
- VOFF_W, 5, voltage offset code width (grid rows 0..cfg_voff_last).
- DWELL_W, 20, dwell length counter width (UI per point).
- ERR_W, 20, error counter width, saturating.
- SETTLE_CYC, 16, cycles waited after moving the sampler before counting; must be ≥1.

Ports:
- clk  in  1  UI-rate clock, 1 sample per cycle.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse that starts a scan; honoured only in IDLE.
- abort  in  1  level; forces IDLE from any state.
- cfg_phase_last  in  PHASE_W  last phase code; latched at start.
- cfg_voff_last  in  VOFF_W  last voltage offset code; latched at start.
- cfg_dwell  in  DWELL_W  UI counted per point; latched at start; 0 is treated as 1.
- cfg_err_thresh  in  ERR_W  point is open if err_cnt ≤ thresh; latched at start.
- cdr_lock  in  1  CDR lock indication.
- data_main  in  1  main-slicer recovered bit.
- data_margin  in  1  margin-slicer bit, same UI.
- margin_en  out  1  enables the margin sampler.
- margin_phase  out  PHASE_W  current phase code.
- margin_voff  out  VOFF_W  current voltage offset code.
- res_valid  out  1  result record valid.
- res_ready  in  1  consumer accepts the record.
- res_phase  out  PHASE_W  record phase.
- res_voff  out  VOFF_W  record voltage offset.
- res_err_cnt  out  ERR_W  mismatches counted over the dwell.
- res_open  out  1  res_err_cnt ≤ latched threshold.
- res_sat  out  1  error counter saturated.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse when the scan completes.
- lock_drops  out  8  saturating count of points restarted due to lock loss; cleared on start.

Behaviour:
- Reset: state IDLE; all outputs 0; lock_drops = 0.
- FSM states: IDLE, WAIT_LOCK, SETTLE, DWELL, REPORT, DONE.
- IDLE, start=1: latch the cfg inputs; phase = 0, voff = 0; clear lock_drops. Next cycle: WAIT_LOCK with margin_en = 1.
- WAIT_LOCK, cdr_lock=1: load the settle counter with SETTLE_CYC and go to SETTLE. The state is held with no timeout.
- SETTLE: counts SETTLE_CYC cycles, then clears err_cnt and the dwell counter and goes to DWELL.
- DWELL: each cycle, err_cnt += (data_main ^ data_margin), saturating at 2^ERR_W−1; res_sat is set when saturation is hit. After exactly max(cfg_dwell,1) counted cycles, register the record and go to REPORT.
- REPORT: res_valid = 1, with all res_* fields stable until res_ready = 1. Transfer occurs on the cycle where valid && ready.
- After transfer, advance the grid. voff is the inner loop: voff++, and when voff == last, voff = 0 and phase++.
- If the transferred point was (phase_last, voff_last), go to DONE. Otherwise go to WAIT_LOCK, which passes through in 1 cycle when locked.
- Throughput with res_ready tied high: SETTLE_CYC + dwell + 2 cycles per point.
- DONE: done = 1 for one cycle, margin_en = 0, then IDLE.
- Lock loss (cdr_lock = 0) in SETTLE or DWELL: discard the partial count, increment lock_drops (saturating at 255), go to WAIT_LOCK, and redo the same point.
- Lock loss in REPORT is ignored, since the record is complete.
- abort (highest priority): in the next cycle, state = IDLE and res_valid, margin_en and busy all drop to 0. This is the sole permitted valid withdrawal.
- start while busy is ignored. cfg changes while busy have no effect.
- cfg_phase_last = 0 and cfg_voff_last = 0 gives a single-point scan.
- margin_phase and margin_voff change only on grid advance or at start, never during SETTLE or DWELL.

Decomposition:
- eye_scan_pkg holds:
  - the state enum (scan_state_e);
  - the result record struct (eye_point_t: phase, voff, err_cnt, open, sat);
  - the lock_drops width constant (8).
- One sub-module, eye_err_accum. It contains the dwell down-counter and the saturating XOR error counter, with a clear/enable interface and a dwell_done flag.

Test Plan:
- Full grid with zero errors: phase_last = 3, voff_last = 1, dwell = 100, data_margin = data_main, ready = 1 → 8 records in order (0,0), (0,1), (1,0) … (3,1), each err = 0 and open = 1; done pulses once; each point spaced 118 cycles (SETTLE_CYC + 100 + 2).
- Inverted margin bit: dwell = 50, thresh = 10 → err_cnt = 50, open = 0. With ERR_W overridden to 4 and dwell = 50 → err_cnt = 15, sat = 1.
- Backpressure: hold res_ready = 0 for 20 cycles in REPORT → res_valid stays 1, fields stable, no grid advance; the record transfers on the first ready cycle.
- Lock loss: drop cdr_lock for 5 cycles mid-DWELL at point (2,0) → lock_drops = 1 and (2,0) is re-measured with a full dwell. Dropping lock during SETTLE gives the same result. Dropping lock during REPORT has no effect.
- Abort / restart: abort at point (1,1) while in REPORT → next cycle res_valid = 0, busy = 0, margin_en = 0. A subsequent start re-scans from (0,0) with lock_drops cleared.
- Edge config: dwell = 0 → counts 1 UI. Single-point grid → 1 record then done. start pulse while busy → ignored. Asynchronous reset mid-DWELL → all outputs 0 immediately.
